compute_arbiter: RTL and testbench

- Round-robin scheduler that shares the single shared compute unit among NUM_UNITS requesting units.
- Accepts level requests with an operation type, selects one requester, and issues a single-cycle request to the compute unit with that requester's ID and type.
- Waits for the unit's done pulse, then returns a one-hot done (or timeout error) pulse to the owner.
- Sits between the accelerator's unit controllers and the shared compute unit; the data-path mux is external and is steered by grant_o.

---
 rtl/compute_arbiter.sv | 132 +++++++++++++
 tb/tb_compute_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/compute_arbiter.sv
// compute_arbiter
//   Round-robin scheduler that shares one compute unit among NUM_UNITS
//   requesters. It picks a requester, issues one request pulse to the compute
//   unit, waits for completion (or a timeout) and then pulses done/err back
//   to the owner.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_i           level request per unit (held until done_o/err_o)
//   op_i            per-unit op type, unit k at [k*COMP_W +: COMP_W]
//   grant_o         one-hot owner, steers the external data mux
//   done_o, err_o   one-cycle completion / timeout pulse to the owner
//   busy_o          high whenever the FSM is not idle
//   cu_ready_i      compute unit can accept a request
//   cu_request_o    request pulse to the compute unit
//   cu_unit_id_o    owner index presented to the compute unit
//   cu_comp_type_o  op type latched from the owner
//   cu_done_i       compute unit completion pulse
module compute_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int ID_W      = 2,
  parameter int COMP_W    = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_UNITS-1:0]        req_i,
  input  logic [NUM_UNITS*COMP_W-1:0] op_i,
  output logic [NUM_UNITS-1:0]        grant_o,
  output logic [NUM_UNITS-1:0]        done_o,
  output logic [NUM_UNITS-1:0]        err_o,
  output logic                        busy_o,
  input  logic                        cu_ready_i,
  output logic                        cu_request_o,
  output logic [ID_W-1:0]             cu_unit_id_o,
  output logic [COMP_W-1:0]           cu_comp_type_o,
  input  logic                        cu_done_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam int CNT_W = 10;

  logic [1:0]       state;
  logic [ID_W-1:0]  idx;
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] cnt;

  // Round-robin pick: first set request at or above ptr, wrapping modulo
  // NUM_UNITS. sum carries one extra bit so ptr+i cannot overflow before
  // the wrap.
  logic            found;
  logic [ID_W-1:0] win;
  logic [ID_W:0]   sum;

  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_UNITS)) sum = sum - (ID_W+1)'(NUM_UNITS);
      if (!found && req_i[sum[ID_W-1:0]]) begin
        found = 1'b1;
        win   = sum[ID_W-1:0];
      end
    end
  end

  assign busy_o       = (state != S_IDLE);
  assign cu_request_o = (state == S_ISSUE) && cu_ready_i;
  assign cu_unit_id_o = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      idx            <= '0;
      ptr            <= '0;
      cnt            <= '0;
      grant_o        <= '0;
      done_o         <= '0;
      err_o          <= '0;
      cu_comp_type_o <= '0;
    end else begin
      // done/err are single-cycle: only the WAIT->RESP transition sets them.
      done_o <= '0;
      err_o  <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            idx            <= win;
            grant_o        <= NUM_UNITS'(1) << win;
            cu_comp_type_o <= op_i[int'(win)*COMP_W +: COMP_W];
            state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Stall here indefinitely while the compute unit is not ready.
          if (cu_ready_i) begin
            cnt   <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          // Completion takes priority over a coincident timeout.
          if (cu_done_i) begin
            done_o <= NUM_UNITS'(1) << idx;
            state  <= S_RESP;
          end else if (cnt == CNT_W'(TIMEOUT-1)) begin
            err_o <= NUM_UNITS'(1) << idx;
            state <= S_RESP;
          end
        end
        default: begin // S_RESP
          grant_o <= '0;
          ptr     <= (idx == ID_W'(NUM_UNITS-1)) ? '0 : idx + 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  a_grant_oh:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_o));
  a_done_oh:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(done_o));
  a_err_oh:    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(err_o));
  a_done_err:  assert property (@(posedge clk) disable iff (!rst_n) !(|done_o && |err_o));
  a_req_issue: assert property (@(posedge clk) disable iff (!rst_n) cu_request_o |-> state == S_ISSUE);

endmodule

// File: tb/tb_compute_arbiter.sv
module tb_compute_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [7:0] op = '0;
  logic [3:0] grant_o, done_o, err_o;
  logic       busy_o;
  logic       cu_ready = 1'b1;
  logic       cu_request_o;
  logic [1:0] cu_unit_id_o, cu_comp_type_o;
  logic       cu_done = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  compute_arbiter #(.NUM_UNITS(4), .ID_W(2), .COMP_W(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .op_i(op),
    .grant_o(grant_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
    .cu_ready_i(cu_ready), .cu_request_o(cu_request_o),
    .cu_unit_id_o(cu_unit_id_o), .cu_comp_type_o(cu_comp_type_o),
    .cu_done_i(cu_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // From IDLE with req/op already driven: grant, issue, done after l cycles.
  task automatic run_op(input int u, input int l, input logic [1:0] t);
    tick;
    chk("rr_grant", grant_o, 32'(1 << u));
    chk("rr_req", cu_request_o, 1);
    chk("rr_id", cu_unit_id_o, u);
    chk("rr_type", cu_comp_type_o, t);
    tick;
    repeat (l-1) tick;
    cu_done = 1'b1;
    tick;
    cu_done = 1'b0;
    chk("rr_done", done_o, 32'(1 << u));
    chk("rr_err", err_o, 0);
    tick;
    chk("rr_done_clr", done_o, 0);
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_grant", grant_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_req", cu_request_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    tick;
    rst_n = 1'b1;

    // single request, unit 2, op 2, done 5 cycles after request
    req = 4'b0100; op = 8'h20; cu_ready = 1'b1;
    tick;
    chk("s_grant", grant_o, 4'b0100);
    chk("s_req", cu_request_o, 1);
    chk("s_id", cu_unit_id_o, 2);
    chk("s_type", cu_comp_type_o, 2);
    chk("s_busy", busy_o, 1);
    op = 8'hFF;
    tick;
    chk("s_type_hold", cu_comp_type_o, 2);
    chk("s_req_wait", cu_request_o, 0);
    repeat (4) tick;
    cu_done = 1'b1;
    chk("s_done_early", done_o, 0);
    tick;
    cu_done = 1'b0; req = '0;
    chk("s_done", done_o, 4'b0100);
    chk("s_err", err_o, 0);
    chk("s_grant_resp", grant_o, 4'b0100);
    tick;
    chk("s_busy_end", busy_o, 0);
    chk("s_grant_end", grant_o, 0);
    chk("s_done_end", done_o, 0);

    // round robin from a fresh pointer
    rst_n = 1'b0; tick; rst_n = 1'b1;
    req = 4'b1111; op = 8'hE4;
    for (int k = 0; k < 8; k++) run_op(k % 4, 2, 2'(k % 4));
    req = '0;

    // backpressure on unit 0 (pointer back at 0)
    cu_ready = 1'b0; req = 4'b0001;
    tick;
    chk("bp_grant", grant_o, 4'b0001);
    chk("bp_req0", cu_request_o, 0);
    for (int k = 0; k < 10; k++) begin
      tick;
      chk("bp_req", cu_request_o, 0);
      chk("bp_hold", grant_o, 4'b0001);
      chk("bp_err", err_o, 0);
    end
    cu_ready = 1'b1;
    #1;
    chk("bp_req_rise", cu_request_o, 1);
    tick;
    chk("bp_req_once", cu_request_o, 0);
    cu_done = 1'b1;
    tick;
    cu_done = 1'b0; req = '0;
    chk("bp_done", done_o, 4'b0001);
    tick;

    // timeout on unit 1 (pointer 1), then done in last counted cycle on unit 3
    req = 4'b1010;
    tick;
    chk("to_grant", grant_o, 4'b0010);
    tick; // WAIT entry
    for (int k = 0; k < 7; k++) begin
      tick;
      chk("to_wait_err", err_o, 0);
    end
    tick;
    chk("to_err", err_o, 4'b0010);
    chk("to_done", done_o, 0);
    tick;
    chk("to_err_clr", err_o, 0);
    tick;
    chk("to_next_grant", grant_o, 4'b1000);
    chk("to_next_type", cu_comp_type_o, 3);
    tick; // WAIT entry
    repeat (7) tick;
    cu_done = 1'b1;
    tick;
    cu_done = 1'b0; req = '0;
    chk("to_edge_done", done_o, 4'b1000);
    chk("to_edge_err", err_o, 0);
    tick;

    // requester drops during WAIT (pointer 0)
    req = 4'b0001;
    tick;
    chk("dr_grant", grant_o, 4'b0001);
    tick;
    req = '0;
    tick; tick;
    cu_done = 1'b1;
    tick;
    cu_done = 1'b0;
    chk("dr_done", done_o, 4'b0001);
    tick;
    req = 4'b0011;
    tick;
    chk("dr_ptr", grant_o, 4'b0010);
    tick;
    cu_done = 1'b1;
    tick;
    cu_done = 1'b0; req = '0;
    chk("dr_done2", done_o, 4'b0010);
    tick;

    // reset mid-WAIT with pointer at 2
    req = 4'b1000;
    tick;
    chk("rw_grant", grant_o, 4'b1000);
    tick; tick;
    rst_n = 1'b0;
    #1;
    chk("rw_grant0", grant_o, 0);
    chk("rw_busy0", busy_o, 0);
    chk("rw_req0", cu_request_o, 0);
    chk("rw_id0", cu_unit_id_o, 0);
    chk("rw_type0", cu_comp_type_o, 0);
    chk("rw_done0", done_o, 0);
    chk("rw_err0", err_o, 0);
    tick;
    rst_n = 1'b1; req = '0; cu_done = 1'b1;
    tick;
    cu_done = 1'b0;
    chk("rw_late_done", done_o, 0);
    chk("rw_late_busy", busy_o, 0);
    req = 4'b0110;
    run_op(1, 2, 2'd1);
    req = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
